// File: rtl/dmem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp_if
// Description : CPU data-port request/response bundle for dmem_resp.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_resp_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output req, we, addr, wdata, size,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, addr, wdata, size,
        output rdata, ready, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp
// Description : Fixed-latency data memory with byte/half/word access, sign
//               extension and misalignment flagging. Optional MMIO output
//               register and cycle counter enabled by macro DMEM_MMIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  wire         clk,
    input  wire         reset,
    dmem_resp_if.slave  bus
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    localparam int         c_idx_w     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        ld_en_q, ld_en_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ram_rd_q;
    logic [c_idx_w-1:0] idx;
    logic        req_err;
    logic        commit;
    logic        ram_we;
    logic        mmio_hit;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic [31:0] ld_word;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    assign idx = addr_q[c_idx_w+1:2];

    always_comb begin
        req_err = 1'b0;
        case (size_q)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = addr_q[0];
            3'b010:         req_err = (addr_q[1:0] != 2'b00);
            default:        req_err = 1'b1;
        endcase
        if (mmio_hit && size_q != 3'b010) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        ld_en_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    size_d  = bus.size;
                    cnt_d   = c_wait_init;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    err_d   = req_err;
                    ld_en_d = !we_q && !req_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 3'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            ld_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            ld_en_q <= ld_en_d;
        end
    end

    // Stores land on the edge leaving RESP; reset forces IDLE so a pending store is dropped.
    assign commit = (state_q == S_RESP) && we_q && !req_err;
    assign ram_we = commit && !mmio_hit;

    always_comb begin
        case (size_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
        ram_rd_q <= mem[idx];
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q, mmio_d;
    logic [31:0] cyc_q, cyc_d;
    logic        mmio_reg_hit;
    logic        mmio_cnt_hit;

    assign mmio_hit     = (addr_q[31:3] == 29'h1FFF_E000);
    assign mmio_reg_hit = mmio_hit && !addr_q[2];
    assign mmio_cnt_hit = mmio_hit && addr_q[2];

    always_comb begin
        cyc_d  = cyc_q + 32'd1;
        mmio_d = mmio_q;
        if (commit && mmio_reg_hit) begin
            mmio_d = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmio_q <= 32'd0;
            cyc_q  <= 32'd0;
        end else begin
            mmio_q <= mmio_d;
            cyc_q  <= cyc_d;
        end
    end

    assign mmio_out = mmio_q;

    always_comb begin
        ld_word = ram_rd_q;
        if (mmio_reg_hit) begin
            ld_word = mmio_q;
        end else if (mmio_cnt_hit) begin
            ld_word = cyc_q;
        end
    end
`else
    logic unused_addr_hi;

    assign mmio_hit       = 1'b0;
    assign unused_addr_hi = ^addr_q[31:c_idx_w+2];
    assign ld_word        = ram_rd_q;
`endif

    always_comb begin
        ld_shift = ld_word >> {addr_q[1:0], 3'b000};
        case (size_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'd0, ld_shift[7:0]};
            3'b101:  ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    assign bus.rdata = ld_en_q ? ld_data : 32'd0;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_resp
// Description : Scoreboard bench for dmem_resp against a byte-array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;
    localparam int DEPTH_WORDS = 1024;
    localparam int WAIT_CYCLES = 2;
    localparam int MEM_BYTES   = DEPTH_WORDS * 4;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_ON = 1'b1;
`else
    localparam bit MMIO_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dmem_resp_if bus();
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_out;
`endif

    dmem_resp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_MMIO_EN
        ,
        .mmio_out (mmio_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          dc;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_rdata = 32'd0;
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] ref_mmio = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_chk++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req_v, cyc);
        end
    endtask

    // Reference model: memory is a flat byte array, accesses are n-byte slices.
    function automatic int acc_bytes(input logic [2:0] s);
        return 1 << s[1:0];
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return MMIO_ON && (a >= 32'hFFFF_0000) && (a <= 32'hFFFF_0007);
    endfunction

    function automatic bit ref_err(input logic [31:0] a, input logic [2:0] s);
        bit bad;
        bad = !(s inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (!bad && (int'(a[1:0]) % acc_bytes(s)) != 0) bad = 1'b1;
        if (is_mmio(a) && s != 3'b010) bad = 1'b1;
        return bad;
    endfunction

    task automatic ref_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] s, output logic [31:0] rd, output logic er);
        int n;
        int base;
        logic [31:0] v;
        rd = 32'd0;
        er = ref_err(a, s);
        if (er) return;
        n = acc_bytes(s);
        if (is_mmio(a)) begin
            if (w && !a[2]) ref_mmio = d;
            if (!w && !a[2]) rd = ref_mmio;
            return;
        end
        base = int'(a & 32'(MEM_BYTES - 1));
        if (w) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | ({24'd0, ref_mem[base + i]} << (8 * i));
            if (!s[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] s, input bit dc, output int acc);
        exp_t e;
        logic [31:0] r;
        logic er;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.size = s;
        @(posedge clk);
        #1;
        acc = cyc;
        ref_access(w, a, d, s, r, er);
        e.rdata = r; e.err = er; e.dc = dc; e.cyc = acc + WAIT_CYCLES;
        exp_q.push_back(e);
        // Junk requests while busy must be ignored by the DUT.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ready) begin
                bus.req = 1'b0;
                return;
            end
            bus.req   = 1'($urandom_range(0, 1));
            bus.we    = 1'($urandom_range(0, 1));
            bus.addr  = $urandom;
            bus.wdata = $urandom;
            bus.size  = 3'($urandom_range(0, 7));
        end
        n_chk++;
        n_fail++;
        $display("FAIL ready_timeout: got no ready within 40 cycles, expected ready at cycle %0d", e.cyc);
        exp_q.delete();
        bus.req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got ready=1 expected ready=0 at cycle %0d", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ready_cycle", cyc, mon_e.cyc);
                    chk("err", {31'd0, bus.err}, {31'd0, mon_e.err});
                    if (mon_e.dc) last_rdata = bus.rdata;
                    else chk("rdata", bus.rdata, mon_e.rdata);
                end
            end else begin
                chk("idle_rdata", bus.rdata, 32'd0);
                chk("idle_err", {31'd0, bus.err}, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int acc2;
        logic [31:0] c1;
        logic rw;
        logic [2:0] rs;
        logic [31:0] ra;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0; bus.size = 3'd0;
        #1;
        chk("reset_ready", {31'd0, bus.ready}, 32'd0);
        chk("reset_err", {31'd0, bus.err}, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 64; i++) issue(1'b1, 32'(i * 4), $urandom, 3'b010, 1'b0, acc);

        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b0, acc);
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b0, acc);

        issue(1'b1, 32'h20, 32'h0, 3'b010, 1'b0, acc);
        issue(1'b1, 32'h21, 32'h80, 3'b000, 1'b0, acc);
        issue(1'b0, 32'h21, 32'h0, 3'b000, 1'b0, acc);
        issue(1'b0, 32'h21, 32'h0, 3'b100, 1'b0, acc);
        issue(1'b0, 32'h20, 32'h0, 3'b010, 1'b0, acc);

        issue(1'b1, 32'h30, 32'h1111_1111, 3'b010, 1'b0, acc);
        issue(1'b0, 32'h31, 32'h0, 3'b001, 1'b0, acc);
        issue(1'b1, 32'h32, 32'h1234_5678, 3'b010, 1'b0, acc);
        issue(1'b0, 32'h30, 32'h0, 3'b010, 1'b0, acc);

        issue(1'b1, 32'h1004, 32'hA5A5_A5A5, 3'b010, 1'b0, acc);
        issue(1'b0, 32'h0004, 32'h0, 3'b010, 1'b0, acc);

        // Reset while the store to 0x40 is waiting: no pulse, no write.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.wdata = 32'h55; bus.size = 3'b010;
        @(negedge clk);
        bus.req = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_wait_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_wait_rdata", bus.rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        issue(1'b0, 32'h40, 32'h0, 3'b010, 1'b0, acc);

`ifdef DMEM_MMIO_EN
        issue(1'b1, 32'hFFFF_0000, 32'h3C, 3'b010, 1'b0, acc);
        @(negedge clk);
        chk("mmio_out", mmio_out, ref_mmio);
        issue(1'b0, 32'hFFFF_0004, 32'h0, 3'b010, 1'b1, acc);
        @(posedge clk);
        c1 = last_rdata;
        repeat (10 - (WAIT_CYCLES + 2)) @(negedge clk);
        issue(1'b0, 32'hFFFF_0004, 32'h0, 3'b010, 1'b1, acc2);
        @(posedge clk);
        chk("mmio_cnt_delta", last_rdata - c1, 32'(acc2 - acc));
        issue(1'b1, 32'hFFFF_0000, 32'h12, 3'b000, 1'b0, acc);
        issue(1'b1, 32'hFFFF_0004, 32'h99, 3'b010, 1'b0, acc);
        issue(1'b0, 32'hFFFF_0000, 32'h0, 3'b010, 1'b0, acc);
`endif

        for (int t = 0; t < 300; t++) begin
            rw = 1'($urandom_range(0, 1));
            rs = 3'($urandom_range(0, 7));
            if (rw && (rs == 3'b100 || rs == 3'b101)) rs = {1'b0, rs[1:0]};
            ra = ($urandom & 32'h7FFF_F000) | 32'($urandom_range(0, 255));
            issue(rw, ra, $urandom, rs, 1'b0, acc);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL be the RAM size in 32-bit words (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL be the cycles from request acceptance to the ready pulse (legal range 1..15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  request valid from the CPU data port.
REQ-006 we  input  1  1 = store, 0 = load (CPU mem_w).
REQ-007 addr  input  32  byte address (CPU ALU result).
REQ-008 wdata  input  32  store data, right-aligned (CPU rs2 value).
REQ-009 size  input  3  access type, funct3 encoding: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-010 rdata  output  32  load result, extended per size.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 err  output  1  misaligned or illegal-size flag, valid only with ready.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1 at a rising edge, the block SHALL capture we, addr, wdata and size, load the wait counter with WAIT_CYCLES-1, and enter WAIT.
REQ-015 In IDLE, req=0 SHALL keep the FSM in IDLE.
REQ-016 WAIT SHALL decrement the counter each cycle and enter RESP on the edge where the counter equals 0.
REQ-017 ready SHALL be 1 only in RESP, i.e. exactly WAIT_CYCLES cycles after the acceptance edge, for exactly one cycle.
REQ-018 RESP SHALL always return to IDLE.
REQ-019 req SHALL be ignored in WAIT and RESP; the next request is accepted at the earliest in the cycle after ready.
REQ-020 The RAM word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-021 A store SHALL commit on the edge that leaves RESP: sb writes byte lane addr[1:0] with wdata[7:0], sh writes half addr[1] with wdata[15:0], sw writes the full word; other lanes SHALL be unchanged.
REQ-022 A load SHALL drive rdata during RESP from the addressed lane: lb/lh sign-extended, lbu/lhu zero-extended, lw unmodified.
REQ-023 rdata SHALL be 0 outside RESP and for stores.
REQ-024 err SHALL be 1 in RESP when the access is misaligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0) or size is 011, 110 or 111.
REQ-025 When err=1, no RAM write SHALL occur and rdata SHALL be 0.
REQ-026 RAM SHALL be a single-port synchronous array; a load issued after a store to the same word SHALL return the stored data.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, ready=0, err=0 and rdata=0, and clear the wait counter and captured request.
REQ-028 Reset during WAIT or RESP SHALL drop the pending request with no RAM write.
REQ-029 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With macro DMEM_MMIO_EN defined, addr 0xFFFF_0000 SHALL map to a 32-bit read/write output register (reset 0), and addr 0xFFFF_0004 SHALL map to a read-only free-running cycle counter (reset 0, wraps at 2^32); both SHALL accept word accesses only (any other size gives err=1); stores to 0xFFFF_0004 SHALL be ignored without error; the output register SHALL be exported as port mmio_out (output, 32 bits).
REQ-031 Without DMEM_MMIO_EN, those addresses SHALL wrap into RAM per REQ-020 and the port mmio_out SHALL NOT exist.

Verification
REQ-032 Issue sw addr=0x10, wdata=0xDEADBEEF, then lw 0x10 -> ready exactly 2 cycles after each acceptance; rdata=0xDEADBEEF, err=0.
REQ-033 sw 0x20=0x00000000, sb addr=0x21 wdata=0x80, lb 0x21 and lbu 0x21 -> 0xFFFFFF80 and 0x00000080; lw 0x20 -> 0x00008000.
REQ-034 sw 0x30=0x11111111, then lh addr=0x31 and sw addr=0x32 wdata=0x12345678 -> err=1 for both; lw 0x30 -> 0x11111111.
REQ-035 With DEPTH_WORDS=1024: sw addr=0x1004 wdata=0xA5A5A5A5, then lw 0x0004 -> 0xA5A5A5A5 (wrap).
REQ-036 Accept sw 0x40=0x55 then assert reset during WAIT -> ready never pulses; lw 0x40 after reset returns the prior RAM value.
REQ-037 With DMEM_MMIO_EN: sw 0xFFFF0000=0x3C -> mmio_out=0x3C; two lw 0xFFFF0004 issued 10 cycles apart -> counter difference 10; sb 0xFFFF0000 -> err=1.
